// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore control FSM for the multi-cycle LEGv8 datapath. It sequences
// fetch, decode, execute, memory access and write-back. It drives every
// datapath strobe and the 2-bit ALUOp consumed by alu_control.
//
// The instruction class is decoded from the IR opcode while in DECODE and is
// captured in a class register on the DECODE exit edge. All later states
// use only that captured class, so the IR may change freely after DECODE.
//
// Outputs are combinational from the current state. The exceptions are the
// mem_ready gating in FETCH and the zero gating in BRANCH. While reset is
// high, every output, including the debug state, is forced to zero.
//
// Optional feature macro: MC_CBNZ_EN
//   defined   -> CBNZ (opcode[10:3] = 10110101) is decoded and branches when
//                the zero flag is clear.
//   undefined -> CBNZ is treated as an unsupported opcode.
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   opcode     in  11  IR[31:21]
//   zero       in   1  ALU zero flag
//   mem_ready  in   1  memory finished the current read/write this cycle
//   pc_en      out  1  PC load enable
//   pc_source  out  2  00 ALU result, 01 ALUOut (branch), 10 ALUOut (B)
//   ior_d      out  1  0 instruction address (PC), 1 data address (ALUOut)
//   mem_read   out  1  memory read request
//   mem_write  out  1  memory write request
//   ir_write   out  1  IR load enable
//   reg2loc    out  1  read-port-2 select: 1 Rt, 0 Rm
//   reg_write  out  1  register file write enable
//   mem_to_reg out  1  write-back source: 1 MDR, 0 ALUOut
//   alu_src_a  out  1  0 PC, 1 register A
//   alu_src_b  out  2  00 B, 01 const 4, 10 D-offset, 11 branch offset<<2
//   alu_op     out  2  00 add, 01 pass B, 10 R-type decode
//   illegal    out  1  one-cycle pulse in DECODE for unsupported opcodes
//   state      out  4  current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic [1:0]  pc_source,
    output logic        ior_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg2loc,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_LDUR  = 3'd1,
        CLS_STUR  = 3'd2,
        CLS_RTYPE = 3'd3,
        CLS_CBZ   = 3'd4,
        CLS_CBNZ  = 3'd5,
        CLS_B     = 3'd6
    } cls_t;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [5:0]  OP_B    = 6'b000101;

    state_t state_r;
    state_t next_state_s;
    cls_t   class_r;
    cls_t   dec_class_s;

    // Map an IR opcode field onto an instruction class. Unsupported opcodes
    // return CLS_NONE.
    function automatic cls_t decode_class(input logic [10:0] op);
        cls_t c;
        c = CLS_NONE;
        if (op == OP_LDUR) begin
            c = CLS_LDUR;
        end else if (op == OP_STUR) begin
            c = CLS_STUR;
        end else if ((op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_AND) || (op == OP_ORR)) begin
            c = CLS_RTYPE;
        end else if (op[10:3] == OP_CBZ) begin
            c = CLS_CBZ;
`ifdef MC_CBNZ_EN
        end else if (op[10:3] == OP_CBNZ) begin
            c = CLS_CBNZ;
`endif
        end else if (op[10:5] == OP_B) begin
            c = CLS_B;
        end else begin
            c = CLS_NONE;
        end
        return c;
    endfunction

    // State and class registers; the class is captured only on the DECODE exit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            class_r <= CLS_NONE;
        end else begin
            state_r <= next_state_s;
            if (state_r == S_DECODE) begin
                class_r <= dec_class_s;
            end else begin
                class_r <= class_r;
            end
        end
    end

    // Next-state and Moore output decode; reset forces every output low.
    always_comb begin
        next_state_s = S_FETCH;
        dec_class_s  = decode_class(opcode);
        pc_en        = 1'b0;
        pc_source    = 2'b00;
        ior_d        = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg2loc      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        illegal      = 1'b0;
        state        = 4'd0;

        if (reset) begin
            next_state_s = S_FETCH;
        end else begin
            state = state_r;
            case (state_r)
                S_FETCH: begin
                    // PC <= PC + 4 and IR load happen on the ready cycle only
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                    if (mem_ready) begin
                        next_state_s = S_DECODE;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_DECODE: begin
                    // ALUOut <= PC + branch offset, ready for BRANCH
                    alu_src_b = 2'b11;
                    // Instructions that read Rt select it now for the A/B fetch
                    if ((dec_class_s == CLS_STUR) || (dec_class_s == CLS_CBZ) ||
                        (dec_class_s == CLS_CBNZ)) begin
                        reg2loc = 1'b1;
                    end else begin
                        reg2loc = 1'b0;
                    end
                    case (dec_class_s)
                        CLS_LDUR, CLS_STUR: next_state_s = S_MEM_ADDR;
                        CLS_RTYPE:          next_state_s = S_EXEC_R;
                        CLS_CBZ, CLS_CBNZ:  next_state_s = S_BRANCH;
                        CLS_B:              next_state_s = S_JUMP;
                        default: begin
                            illegal      = 1'b1;
                            next_state_s = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    if (class_r == CLS_STUR) begin
                        reg2loc      = 1'b1;
                        next_state_s = S_MEM_WRITE;
                    end else begin
                        reg2loc      = 1'b0;
                        next_state_s = S_MEM_READ;
                    end
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    ior_d    = 1'b1;
                    if (mem_ready) begin
                        next_state_s = S_MEM_WB;
                    end else begin
                        next_state_s = S_MEM_READ;
                    end
                end
                S_MEM_WB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = 1'b1;
                    next_state_s = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    ior_d     = 1'b1;
                    reg2loc   = 1'b1;
                    if (mem_ready) begin
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_MEM_WRITE;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = 2'b00;
                    alu_op       = 2'b10;
                    next_state_s = S_R_WB;
                end
                S_R_WB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = 1'b0;
                    next_state_s = S_FETCH;
                end
                S_BRANCH: begin
                    // ALU passes Rt so zero reflects the tested register
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b00;
                    alu_op    = 2'b01;
                    reg2loc   = 1'b1;
                    pc_source = 2'b01;
`ifdef MC_CBNZ_EN
                    if (class_r == CLS_CBNZ) begin
                        pc_en = ~zero;
                    end else begin
                        pc_en = zero;
                    end
`else
                    pc_en = zero;
`endif
                    next_state_s = S_FETCH;
                end
                S_JUMP: begin
                    pc_en        = 1'b1;
                    pc_source    = 2'b10;
                    next_state_s = S_FETCH;
                end
                default: begin
                    // Unused encodings recover to FETCH with all strobes low
                    next_state_s = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore FSM that sequences the multi-cycle LEGv8 datapath: fetch, decode, execute, memory and write-back.
- Generates every datapath control strobe and the 2-bit ALUOp consumed by `alu_control`.
- Waits on a single-port memory ready handshake.
- Flags opcodes it does not support.
- Sits between the instruction register (IR) opcode field and the datapath muxes/enables.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- opcode  in  11  IR[31:21]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_en  out  1  PC register load enable (PCWrite | PCWriteCond&taken)
- pc_source  out  2  00 ALU result, 01 ALUOut (branch target), 10 ALUOut (B target)
- ior_d  out  1  0 instruction address (PC), 1 data address (ALUOut)
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg2loc  out  1  read-port-2 select: 1 = Rt (IR[4:0]), 0 = Rm
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back source: 1 MDR, 0 ALUOut
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext D-offset, 11 sign-ext branch offset <<2
- alu_op  out  2  to `alu_control`: 00 add, x1 pass B, 1x R-type decode
- illegal  out  1  one-cycle pulse: unsupported opcode
- state  out  4  current state encoding (debug)

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9
  - Encodings 10–15 unused; if reached, go to FETCH.
- Decode classes are matched in DECODE and latched into an internal class register; later states use only the latched class.
  - LDUR: 11111000010
  - STUR: 11111000000
  - R-type ADD/SUB/AND/ORR: 10001011000, 11001011000, 10001010000, 10101010000
  - CBZ: opcode[10:3] = 10110100
  - B: opcode[10:5] = 000101
- Unlisted outputs are 0 in every state.
- FETCH:
  - Outputs: mem_read=1, ior_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_en equal mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (ALUOut ← PC+offset).
  - reg2loc=1 for STUR and CBZ.
  - Next state by class: LDUR/STUR → MEM_ADDR, R-type → EXEC_R, CBZ → BRANCH, B → JUMP.
  - Any other opcode: illegal=1 for this cycle only, next state FETCH.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next: MEM_READ (LDUR) or MEM_WRITE (STUR); reg2loc=1 held for STUR.
- MEM_READ:
  - Outputs: mem_read=1, ior_d=1.
  - Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1; next FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, ior_d=1, reg2loc=1.
  - Hold until mem_ready, then go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB.
- R_WB: reg_write=1, mem_to_reg=0; next FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, reg2loc=1, pc_source=01.
  - pc_en = zero (taken condition).
  - Next FETCH.
- JUMP: pc_en=1, pc_source=10; next FETCH.

## Timing
- Outputs are combinational from state (Moore), except the mem_ready and zero gating noted above. No output is registered.
- Reset:
  - While reset=1, all outputs are forced to 0.
  - Next state is FETCH and the class register is cleared.
  - After reset deasserts, FETCH outputs appear in the first cycle.
  - Reset asserted mid-instruction abandons the instruction at the next edge, even if a memory access is pending.
- Latency with zero-wait memory (mem_ready=1 on first request cycle):
  - R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3, illegal 2.
  - Each wait cycle adds exactly one cycle to FETCH, MEM_READ or MEM_WRITE.
- mem_ready is ignored in all states that make no memory request.
- mem_read/mem_write stay asserted, with ior_d stable, until the ready cycle inclusive.
- Class register loads only in DECODE; opcode changes in other states have no effect.

## Configuration
- MC_CBNZ_EN defined:
  - DECODE also matches CBNZ, opcode[10:3] = 10110101, and goes to BRANCH.
  - In BRANCH for CBNZ, pc_en = ~zero.
- MC_CBNZ_EN undefined: CBNZ is treated as illegal (illegal pulse, back to FETCH).

## Test plan
- Reset held 2 cycles, then released with mem_ready=1 → outputs 0 during reset; then state=0 with mem_read=1, ir_write=1, pc_en=1.
- ADD, opcode 10001011000, zero-wait memory → states 0,1,6,7,0. alu_op=10 in EXEC_R; reg_write=1, mem_to_reg=0 in R_WB.
- LDUR with mem_ready held low 3 cycles in MEM_READ → MEM_READ lasts 4 cycles with mem_read=1, ior_d=1; then MEM_WB with reg_write=1, mem_to_reg=1.
- CBZ:
  - zero=1 → BRANCH has pc_en=1, pc_source=01, alu_op=01.
  - zero=0 → pc_en=0.
  - reg2loc=1 in DECODE in both cases.
- Opcode 11111111111 → illegal=1 in DECODE only; next state 0.
- Same opcode run under MC_CBNZ_EN on/off:
  - Opcode 10110101000, zero=0.
  - Enabled: pc_en=1 in BRANCH.
  - Disabled: illegal pulse.
- Reset asserted while in MEM_WRITE with mem_ready=0 → mem_write=0 in the reset cycle; FETCH after release.
